// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, requester IDs and command type for the memory arbiter
package mem_pkg;
  localparam int MEM_AW = 16;
  localparam int MEM_DW = 8;
  typedef enum logic {REQ_CPU = 1'b0, REQ_DBG = 1'b1} req_id_t;
  typedef struct packed {
    logic we;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two-requester command/grant/read-return bundle
interface mem_arbiter_if import mem_pkg::*; #(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          lock0, lock1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter with bounded lock (hold) support
module rr_arb2 import mem_pkg::*; #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic [1:0] i_lock,
  output logic [1:0] o_gnt
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  req_id_t       r_last;
  logic [HW-1:0] r_hold_cnt;
  req_id_t       w_win;
  logic          w_any;
  logic          w_keep;
  // only the most recent winner's lock counts, and only while under the hold limit
  always_comb begin
    w_any  = (|i_req) && !rst;
    w_keep = i_req[r_last] && i_lock[r_last] && (r_hold_cnt < HOLD_MAX);
    w_win  = (i_req == 2'b11) ? (w_keep ? r_last : req_id_t'(~r_last)) : req_id_t'(i_req[1]);
    o_gnt  = !w_any ? 2'b00 : (w_win == REQ_DBG) ? 2'b10 : 2'b01;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= REQ_DBG;
      r_hold_cnt <= '0;
    end else if (!w_any) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= (w_win != r_last) ? HW'(1) : (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + 1'b1;
      r_last     <= w_win;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM port between a CPU and a loader/debug requester
module mem_arbiter import mem_pkg::*; #(
  parameter int AW       = MEM_AW,
  parameter int DW       = MEM_DW,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do
);
  logic [1:0]    w_gnt;
  logic          w_sel;
  logic          w_xfer;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [AW-1:0] r_ram_addr;
  logic          r_ram_we;
  logic [DW-1:0] r_ram_di;
  logic          r_rd_v1, r_rd_v2;
  req_id_t       r_rd_id1, r_rd_id2;
  rr_arb2 #(.MAX_HOLD(MAX_HOLD)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req  ({bus.req1, bus.req0}),
    .i_lock ({bus.lock1, bus.lock0}),
    .o_gnt  (w_gnt)
  );
  always_comb begin
    w_sel       = w_gnt[1];
    w_xfer      = |w_gnt;
    w_we        = w_sel ? bus.we1 : bus.we0;
    w_addr      = w_sel ? bus.addr1 : bus.addr0;
    w_wdata     = w_sel ? bus.wdata1 : bus.wdata0;
    bus.gnt0    = w_gnt[0];
    bus.gnt1    = w_gnt[1];
    bus.rvalid0 = r_rd_v2 && (r_rd_id2 == REQ_CPU) && !rst;
    bus.rvalid1 = r_rd_v2 && (r_rd_id2 == REQ_DBG) && !rst;
    bus.rdata0  = ram_do;
    bus.rdata1  = ram_do;
  end
  // stage 1 tags the cycle the RAM sees the address, stage 2 the cycle ram_do is valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_addr <= '0;
      r_ram_we   <= 1'b0;
      r_ram_di   <= '0;
      r_rd_v1    <= 1'b0;
      r_rd_v2    <= 1'b0;
      r_rd_id1   <= REQ_CPU;
      r_rd_id2   <= REQ_CPU;
    end else begin
      r_ram_we <= w_xfer && w_we;
      if (w_xfer) begin
        r_ram_addr <= w_addr;
        r_ram_di   <= w_wdata;
      end
      r_rd_v1  <= w_xfer && !w_we;
      r_rd_id1 <= req_id_t'(w_sel);
      r_rd_v2  <= r_rd_v1;
      r_rd_id2 <= r_rd_id1;
    end
  end
  assign ram_addr = r_ram_addr;
  assign ram_we   = r_ram_we;
  assign ram_di   = r_ram_di;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with a request-level reference model and per-cycle comparison
module tb_mem_arbiter;
  import mem_pkg::*;
  localparam int MAX_HOLD = 4;
  localparam int NLOG = 256;
  localparam logic [1:0] LOCK_GNT [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
  localparam logic [3:0] F_VEC [8] = '{4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1110, 4'b1101, 4'b1110};
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_di;
  logic [7:0]  ram_do;
  mem_arbiter_if #(.AW(16), .DW(8)) bus ();
  mem_arbiter #(.AW(16), .DW(8), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_di(ram_di), .ram_do(ram_do)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction
  // synchronous RAM: one-cycle read latency, unwritten locations read a fixed pattern
  logic [7:0] mem [0:65535];
  bit         written [0:65535];
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_di;
      written[ram_addr] <= 1'b1;
    end
    ram_do <= written[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
  end
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", n, cyc, act, exp);
    end
  endtask
  typedef struct { int due; logic id; logic [7:0] data; } rd_t;
  rd_t         rq[$];
  logic [7:0]  ref_mem [int];
  int          m_last = 1;
  int          m_hold = 0;
  logic        e_we = 1'b0;
  logic [15:0] e_addr = '0;
  logic [7:0]  e_di = '0;
  logic [1:0]  log_gnt [NLOG];
  logic        log_we [NLOG];
  logic        log_rv0 [NLOG];
  logic        log_rv1 [NLOG];
  logic [7:0]  log_rd0 [NLOG];
  logic [7:0]  log_rd1 [NLOG];
  always @(negedge clk) begin : cmp
    int          w;
    logic [1:0]  eg;
    logic        erv0, erv1, cwe;
    logic [7:0]  erd, cd;
    logic [15:0] ca;
    rd_t         r;
    w = -1;
    if (!rst) begin
      if (bus.req0 && !bus.req1) w = 0;
      else if (bus.req1 && !bus.req0) w = 1;
      else if (bus.req0 && bus.req1)
        w = (((m_last == 0) ? bus.lock0 : bus.lock1) && m_hold < MAX_HOLD) ? m_last : 1 - m_last;
    end
    eg = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
    erv0 = 1'b0;
    erv1 = 1'b0;
    erd = '0;
    if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      erv0 = !r.id;
      erv1 = r.id;
      erd = r.data;
    end
    chk("gnt", 32'({bus.gnt1, bus.gnt0}), 32'(eg));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_di", 32'(ram_di), 32'(e_di));
    chk("rvalid", 32'({bus.rvalid1, bus.rvalid0}), 32'({erv1, erv0}));
    if (erv0) chk("rdata0", 32'(bus.rdata0), 32'(erd));
    if (erv1) chk("rdata1", 32'(bus.rdata1), 32'(erd));
    if (cyc < NLOG) begin
      log_gnt[cyc] = {bus.gnt1, bus.gnt0};
      log_we[cyc]  = ram_we;
      log_rv0[cyc] = bus.rvalid0;
      log_rv1[cyc] = bus.rvalid1;
      log_rd0[cyc] = bus.rdata0;
      log_rd1[cyc] = bus.rdata1;
    end
    if (rst) begin
      m_last = 1;
      m_hold = 0;
      e_we = 1'b0;
      e_addr = '0;
      e_di = '0;
      rq.delete();
    end else if (w < 0) begin
      m_hold = 0;
      e_we = 1'b0;
    end else begin
      m_hold = (w == m_last) ? ((m_hold < MAX_HOLD) ? m_hold + 1 : MAX_HOLD) : 1;
      m_last = w;
      cwe = (w == 0) ? bus.we0 : bus.we1;
      ca  = (w == 0) ? bus.addr0 : bus.addr1;
      cd  = (w == 0) ? bus.wdata0 : bus.wdata1;
      e_we = cwe;
      e_addr = ca;
      e_di = cd;
      if (cwe) ref_mem[int'(ca)] = cd;
      else rq.push_back('{due: cyc + 2, id: 1'(w), data: ref_mem.exists(int'(ca)) ? ref_mem[int'(ca)] : init_val(ca)});
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic p0(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d, input logic l);
    bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; bus.lock0 = l;
  endtask
  task automatic p1(input logic r, input logic w, input logic [15:0] a, input logic [7:0] d, input logic l);
    bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; bus.lock1 = l;
  endtask
  task automatic idle();
    p0(1'b0, 1'b0, '0, '0, 1'b0);
    p1(1'b0, 1'b0, '0, '0, 1'b0);
  endtask
  task automatic do_reset();
    idle();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask
  initial begin
    int   t;
    logic any;
    do_reset();
    step(1);
    // write then read back the same address from the CPU side
    t = cyc;
    p0(1'b1, 1'b1, 16'h0064, 8'h55, 1'b0);
    step(1);
    p0(1'b1, 1'b0, 16'h0064, 8'h00, 1'b0);
    step(1);
    idle();
    step(4);
    chk("A gnt wr", 32'(log_gnt[t]), 32'h1);
    chk("A gnt rd", 32'(log_gnt[t + 1]), 32'h1);
    chk("A ram_we", 32'(log_we[t + 1]), 32'h1);
    chk("A rvalid0", 32'(log_rv0[t + 3]), 32'h1);
    chk("A rdata0", 32'(log_rd0[t + 3]), 32'h55);
    any = 1'b0;
    for (int i = 0; i < 6; i++) any |= log_rv1[t + i];
    chk("A rvalid1 never", 32'(any), 32'h0);
    // both reading, no lock: strict alternation starting with requester 0
    do_reset();
    t = cyc;
    p0(1'b1, 1'b0, 16'h0200, 8'h00, 1'b0);
    p1(1'b1, 1'b0, 16'h0300, 8'h00, 1'b0);
    step(6);
    idle();
    step(3);
    for (int k = 0; k < 6; k++) begin
      chk("B gnt", 32'(log_gnt[t + k]), (k % 2 == 1) ? 32'h2 : 32'h1);
      if (k % 2 == 0) chk("B rdata0", 32'({log_rv0[t + k + 2], log_rd0[t + k + 2]}), 32'h13E);
      else chk("B rdata1", 32'({log_rv1[t + k + 2], log_rd1[t + k + 2]}), 32'h13F);
    end
    // lock0 held while both request: four locked grants then a forced switch
    do_reset();
    t = cyc;
    p0(1'b1, 1'b0, 16'h0400, 8'h00, 1'b1);
    p1(1'b1, 1'b0, 16'h0500, 8'h00, 1'b0);
    step(6);
    idle();
    step(3);
    for (int k = 0; k < 6; k++) chk("C gnt", 32'(log_gnt[t + k]), 32'(LOCK_GNT[k]));
    // reset one cycle after a read grant to requester 1 drops that read
    t = cyc;
    p1(1'b1, 1'b0, 16'h0500, 8'h00, 1'b0);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    p0(1'b1, 1'b0, 16'h0400, 8'h00, 1'b0);
    step(1);
    idle();
    step(4);
    chk("D gnt1", 32'(log_gnt[t]), 32'h2);
    chk("D gnt in rst", 32'(log_gnt[t + 1]), 32'h0);
    chk("D tie after rst", 32'(log_gnt[t + 2]), 32'h1);
    chk("D ram_we", 32'(log_we[t + 2]), 32'h0);
    any = 1'b0;
    for (int i = 1; i < 6; i++) any |= log_rv1[t + i];
    chk("D rvalid1 dropped", 32'(any), 32'h0);
    chk("D rvalid0", 32'(log_rv0[t + 4]), 32'h1);
    // requester 1 alone: 8 writes then 8 reads back to back
    t = cyc;
    for (int i = 0; i < 8; i++) begin
      p1(1'b1, 1'b1, 16'h0010 + 16'(i), 8'(i), 1'b0);
      step(1);
    end
    for (int i = 0; i < 8; i++) begin
      p1(1'b1, 1'b0, 16'h0010 + 16'(i), 8'h00, 1'b0);
      step(1);
    end
    idle();
    step(4);
    any = 1'b1;
    for (int i = 0; i < 16; i++) any &= (log_gnt[t + i] == 2'b10);
    chk("E 16 gnt1", 32'(any), 32'h1);
    for (int i = 0; i < 8; i++) chk("E rdata1", 32'({log_rv1[t + 10 + i], log_rd1[t + 10 + i]}), 32'h100 | 32'(i));
    // lock corner cases: lock without req, saturation, non-winner lock
    t = cyc;
    for (int i = 0; i < 8; i++) begin
      p0(F_VEC[i][3], 1'b0, 16'h0600 + 16'(i), 8'h00, F_VEC[i][1]);
      p1(F_VEC[i][2], 1'b0, 16'h0700 + 16'(i), 8'h00, F_VEC[i][0]);
      step(1);
    end
    idle();
    step(3);
    chk("F saturated switch", 32'(log_gnt[t + 5]), 32'h2);
    chk("F lock1 keeps", 32'(log_gnt[t + 6]), 32'h2);
    chk("F lock0 ignored", 32'(log_gnt[t + 7]), 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 16, address width.
REQ-002 Parameter DW, default 8, data width.
REQ-003 Parameter MAX_HOLD, default 4, max consecutive locked grants to one requester while the other waits.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req0/req1  in  1  requester 0 (CPU) / requester 1 (loader/debug) access request.
REQ-007 we0/we1  in  1  write enable qualifying the request.
REQ-008 addr0/addr1  in  AW  access address.
REQ-009 wdata0/wdata1  in  DW  write data.
REQ-010 lock0/lock1  in  1  request to retain the grant next cycle.
REQ-011 gnt0/gnt1  out  1  request accepted this cycle; combinational.
REQ-012 rvalid0/rvalid1  out  1  read data valid for that requester.
REQ-013 rdata0/rdata1  out  DW  read data; both driven from ram_do.
REQ-014 ram_addr  out  AW  registered RAM address.
REQ-015 ram_we  out  1  registered RAM write enable.
REQ-016 ram_di  out  DW  registered RAM write data.
REQ-017 ram_do  in  DW  RAM read data, valid one cycle after ram_addr is presented.

Function
REQ-018 Transfer occurs in cycle N when reqX and gntX are both high; at most one gnt high per cycle.
REQ-019 Accepted command SHALL appear on ram_addr/ram_we/ram_di in cycle N+1; an idle cycle drives ram_we=0 and holds ram_addr/ram_di.
REQ-020 Read accepted in cycle N SHALL raise rvalidX with rdataX=ram_do for exactly cycle N+2; writes produce no rvalid.
REQ-021 Throughput: one accepted access per cycle, back-to-back, any mix of requesters and read/write.
REQ-022 Two-stage owner/read tag pipeline SHALL route each rvalid to the originating requester.
REQ-023 Single requester: granted in the same cycle it requests.
REQ-024 Both requesting, no lock: round-robin; the requester that did not win the most recent grant wins.
REQ-025 Lock: if last winner holds req and lock, it wins again while hold_cnt < MAX_HOLD; at hold_cnt = MAX_HOLD with the other requesting, grant switches.
REQ-026 hold_cnt counts consecutive grants to the same requester, saturates at MAX_HOLD, reloads to 1 on a grant to the other requester, clears to 0 on a cycle with no grant.
REQ-027 Lock without req is ignored; lock from the non-winning requester is ignored.
REQ-028 Write then read to the same address in consecutive cycles SHALL return the written data (RAM ordering preserved).

Reset
REQ-029 Under rst: ram_we=0, ram_addr=0, ram_di=0, hold_cnt=0, tag pipeline cleared, last winner = requester 1 (so requester 0 wins the first tie).
REQ-030 gnt0/gnt1 SHALL be 0 during any cycle with rst high.
REQ-031 Reads in flight when rst asserts SHALL be dropped; no rvalid in the cycles after reset.

Structure
REQ-032 Shared package mem_pkg holds AW/DW defaults, requester-ID typedef (REQ_CPU=0, REQ_DBG=1) and the command struct {we, addr, wdata}.
REQ-033 One sub-module, rr_arb2: two-input round-robin/lock arbiter with the hold counter; the datapath and tag pipeline stay in mem_arbiter.

Verification
REQ-034 Bench SHALL use the existing behavioural synchronous RAM model attached to the ram_* ports.
REQ-035 req0 write 0x55 @0x0064, next cycle read @0x0064 -> gnt0 both cycles, ram_we=1 in cycle 2, rvalid0 with rdata0=0x55 in cycle 4, rvalid1 never.
REQ-036 req0 and req1 reads held high 6 cycles, no lock -> gnt alternates 0,1,0,1,0,1; each rvalid two cycles after its grant.
REQ-037 Both requesting, lock0=1 held, MAX_HOLD=4 -> gnt0 for 4 cycles, gnt1 on cycle 5, gnt0 on cycle 6.
REQ-038 rst asserted one cycle after read grant to req1 -> no rvalid1 afterward, ram_we=0, next tie granted to req0.
REQ-039 req1 alone, 8 back-to-back writes 0x00..0x07 @0x0010..0x0017, then 8 reads -> 16 consecutive gnt1, read data 0x00..0x07 in order.
